// File: rtl/reg_wb_pkg.sv
// Shared constants and entry type for the register-file writeback controller.
package reg_wb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending register writes: two pushes per edge (a older than b), one pop,
// and the occupied entries exported oldest-first for the bypass search.
module wb_fifo
    import reg_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_a,
    input  wb_entry_t                 entry_a,
    input  logic                      push_b,
    input  wb_entry_t                 entry_b,
    input  logic                      pop,
    output wb_entry_t                 head,
    output logic [$clog2(DEPTH):0]    count,
    output wb_entry_t [DEPTH-1:0]     by_age
);

    localparam int unsigned PW = $clog2(DEPTH);

    wb_entry_t [DEPTH-1:0] mem_q;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, wr_ptr_b, rd_ptr_q, rd_ptr_d;
    logic [PW:0]           count_q, count_d;

    always_comb begin
        wr_ptr_b = wr_ptr_q + PW'(push_a);
        wr_ptr_d = wr_ptr_b + PW'(push_b);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + (PW+1)'(push_a) + (PW+1)'(push_b) - (PW+1)'(pop);
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_a) mem_q[wr_ptr_q] <= entry_a;
            if (push_b) mem_q[wr_ptr_b] <= entry_b;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            by_age[i] = mem_q[rd_ptr_q + PW'(i)];
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-file write-side initiator: arbitrates ALU/load writebacks into a pending buffer,
// drains one write per cycle and corrects read operands. Optional macro: REG_WB_BYPASS_EN.
module reg_wb_ctrl
    import reg_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [ADDR_W-1:0]      alu_rd,
    input  logic [DATA_W-1:0]      alu_data,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [ADDR_W-1:0]      ld_rd,
    input  logic [DATA_W-1:0]      ld_data,
    output logic                   write_enable,
    output logic [ADDR_W-1:0]      write_reg,
    output logic [DATA_W-1:0]      data_in,
    input  logic [ADDR_W-1:0]      read_reg1,
    input  logic [ADDR_W-1:0]      read_reg2,
    input  logic [DATA_W-1:0]      rf_rd1,
    input  logic [DATA_W-1:0]      rf_rd2,
    output logic [DATA_W-1:0]      op_rd1,
    output logic [DATA_W-1:0]      op_rd2,
    output logic                   hazard1,
    output logic                   hazard2,
    output logic [$clog2(DEPTH):0] pend_cnt
);

    localparam int unsigned        CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]      DEPTH_C = CW'(DEPTH);

    wb_entry_t             head;
    wb_entry_t [DEPTH-1:0] by_age;
    logic [CW-1:0]         free_cnt;
    logic                  push_alu, push_ld;
    logic                  hit1, hit2;

    // The head popped this edge frees its slot for a push on the same edge.
    assign free_cnt  = DEPTH_C - pend_cnt + CW'(write_enable);
    assign ld_ready  = (free_cnt != '0);
    assign alu_ready = (free_cnt >= CW'(2));

    assign push_alu = alu_valid && alu_ready && (alu_rd != REG_ZERO);
    assign push_ld  = ld_valid && ld_ready && (ld_rd != REG_ZERO);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_a  (push_alu),
        .entry_a ('{rd: alu_rd, data: alu_data}),
        .push_b  (push_ld),
        .entry_b ('{rd: ld_rd, data: ld_data}),
        .pop     (write_enable),
        .head    (head),
        .count   (pend_cnt),
        .by_age  (by_age)
    );

    assign write_enable = (pend_cnt != '0);
    assign write_reg    = write_enable ? head.rd : REG_ZERO;
    assign data_in      = write_enable ? head.data : '0;

`ifdef REG_WB_BYPASS_EN
    logic [DATA_W-1:0] byp1, byp2;

    // Oldest-first scan: a later (younger) match overrides an earlier one.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        byp1 = '0;
        byp2 = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(i) < pend_cnt) begin
                if (by_age[i].rd == read_reg1) begin
                    hit1 = 1'b1;
                    byp1 = by_age[i].data;
                end
                if (by_age[i].rd == read_reg2) begin
                    hit2 = 1'b1;
                    byp2 = by_age[i].data;
                end
            end
        end
    end

    assign op_rd1  = (read_reg1 == REG_ZERO) ? '0 : (hit1 ? byp1 : rf_rd1);
    assign op_rd2  = (read_reg2 == REG_ZERO) ? '0 : (hit2 ? byp2 : rf_rd2);
    assign hazard1 = 1'b0;
    assign hazard2 = 1'b0;
`else
    logic unused_data;

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(i) < pend_cnt) begin
                if (by_age[i].rd == read_reg1) hit1 = 1'b1;
                if (by_age[i].rd == read_reg2) hit2 = 1'b1;
            end
        end
    end

    // Without bypass only the rd fields are searched; decode stalls on a hit.
    assign unused_data = ^by_age;
    assign op_rd1      = (read_reg1 == REG_ZERO) ? '0 : rf_rd1;
    assign op_rd2      = (read_reg2 == REG_ZERO) ? '0 : rf_rd2;
    assign hazard1     = hit1 && (read_reg1 != REG_ZERO);
    assign hazard2     = hit2 && (read_reg2 != REG_ZERO);
`endif

endmodule
